mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported unified instruction/data memory between the pipeline's fetch stage and its load/store stage. Requesters hold a level request until they receive a one-cycle acknowledge. The arbiter runs one registered memory transaction at a time against a variable-latency memory with a ready handshake. It also exports a registered write-observation port (address, data, active) that the top level brings out for the bench's store checker.

---
 rtl/mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the fetch
// stage (i_*) and the load/store stage (d_*). One registered memory
// transaction runs at a time against a variable-latency memory that signals
// completion with mem_ready. A registered write-observation port (wr_*)
// reports every completed store.
//
// Optional feature: define ARB_STARVE_GUARD_EN to build a starvation guard
// that forces a fetch grant after STARVE_LIMIT consecutive data grants made
// while fetch was waiting. Without it, data has strict priority.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   i_req/i_addr        fetch request (level, held until i_ack) and address
//   i_ack/i_rdata       one-cycle fetch completion pulse and fetched word
//   d_req/d_we/d_be     load/store request, store flag, byte enables
//   d_addr/d_wdata      data address and store data
//   d_ack/d_rdata       one-cycle data completion pulse and load data
//   mem_req             memory transaction active
//   mem_we/mem_be       registered transaction write flag / byte enables
//   mem_addr/mem_wdata  registered transaction address / write data
//   mem_rdata/mem_ready memory read data, completion handshake
//   wr_active           pulse: a store completed (coincident with d_ack)
//   wr_addr/wr_data     address / data of the completed store
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,

    output logic                wr_active,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                i_ack_q, i_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                wr_active_q, wr_active_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    // A requester whose ack is high is still dropping its req this cycle, so
    // its req line must not be read as a new request.
    logic i_elig, d_elig;
    logic ack_cycle;
    logic fetch_first;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;
`endif

    assign i_elig    = i_req && !i_ack_q;
    assign d_elig    = d_req && !d_ack_q;
    // The cycle carrying an ack is the first IDLE cycle after a transaction;
    // no grant is made in it, so the next grant lands in the following cycle.
    assign ack_cycle = i_ack_q || d_ack_q;

`ifdef ARB_STARVE_GUARD_EN
    assign fetch_first = i_elig && d_elig && (starve_q == STARVE_MAX);
`else
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        wr_active_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
`ifdef ARB_STARVE_GUARD_EN
        starve_d    = starve_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (!ack_cycle) begin
                    if (d_elig && !fetch_first) begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_be_d    = d_be;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
`ifdef ARB_STARVE_GUARD_EN
                        // Only data grants that overtook a waiting fetch count.
                        if (i_elig && (starve_q < STARVE_MAX)) begin
                            starve_d = starve_q + 4'd1;
                        end
`endif
                    end else if (i_elig) begin
                        state_d    = BUSY_I;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_be_d   = '1;
                        mem_addr_d = i_addr;
`ifdef ARB_STARVE_GUARD_EN
                        starve_d   = 4'd0;
`endif
                    end
                end
            end

            BUSY_I: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    i_rdata_d = mem_rdata;
                    i_ack_d   = 1'b1;
                end
            end

            BUSY_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    // Read data is captured for stores as well; callers ignore it.
                    d_rdata_d = mem_rdata;
                    d_ack_d   = 1'b1;
                    if (mem_we_q) begin
                        wr_active_d = 1'b1;
                        wr_addr_d   = mem_addr_q;
                        wr_data_d   = mem_wdata_q;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Reset abandons any in-flight transaction; no ack is produced for it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            wr_active_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            wr_active_q <= wr_active_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign wr_active = wr_active_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter. Stimulus pushes the expected
// transaction into a queue; a monitor checks each grant against the queue
// head and pops on every ack, checking port, read data and store observation.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          wr_active;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wr_active(wr_active), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          mem_lat     = 1;
    int          lat_cnt     = 0;
    bit          idle_pulse  = 0;
    logic [31:0] exp_i_hold  = '0;
    logic [31:0] exp_d_hold  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a fixed function of the address so read data identifies
    // which address was actually presented.
    function automatic logic [31:0] memFn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mkExp(input bit is_d, input bit we, input logic [3:0] be,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.is_d = is_d;
        e.we   = we;
        e.be   = is_d ? be : 4'hF;
        e.addr = addr;
        e.data = we ? wdata : memFn(addr);
        return e;
    endfunction

    // Variable-latency memory: ready after mem_lat cycles of mem_req.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req) begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = memFn(mem_addr);
                end
            end else begin
                lat_cnt = 0;
                if (idle_pulse) begin
                    mem_ready = 1'b1;
                    mem_rdata = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Monitor: grant fields against the queue head, pop on each ack.
    initial begin
        bit   prev_req;
        bit   exp_wr;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req = 1'b0;
                continue;
            end
            exp_wr = 1'b0;
            if (mem_req && !prev_req) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_grant_addr", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("grant_addr", mem_addr, sb[0].addr);
                    checkOutput("grant_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                    checkOutput("grant_be", {28'd0, mem_be}, {28'd0, sb[0].be});
                    if (sb[0].we) checkOutput("grant_wdata", mem_wdata, sb[0].data);
                end
            end
            if (i_ack && d_ack) checkOutput("dual_ack", 32'd1, 32'd0);
            if (i_ack || d_ack) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack_d", {31'd0, d_ack}, 32'd2);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ack_port_d", {31'd0, d_ack}, {31'd0, e.is_d});
                    if (e.is_d) begin
                        exp_d_hold = memFn(e.addr);
                        checkOutput("d_rdata", d_rdata, exp_d_hold);
                        exp_wr = d_ack && e.we;
                    end else begin
                        exp_i_hold = e.data;
                        checkOutput("i_rdata", i_rdata, exp_i_hold);
                    end
                    if (exp_wr || wr_active) begin
                        if (exp_wr) begin
                            checkOutput("wr_addr", wr_addr, e.addr);
                            checkOutput("wr_data", wr_data, e.data);
                        end
                    end
                end
            end
            if (exp_wr || wr_active) checkOutput("wr_active", {31'd0, wr_active}, {31'd0, exp_wr});
            prev_req = mem_req;
        end
    end

    // Drives one requester until its ack arrives, then drops req.
    task automatic doReq(input bit is_d, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        logic ack;
        if (is_d) begin
            d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
            ack = is_d ? d_ack : i_ack;
        end while (!ack && n < 60);
        checkOutput(is_d ? "d_ack_seen" : "i_ack_seen", {31'd0, ack}, 32'd1);
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        @(negedge clk); #1;
        ack = is_d ? d_ack : i_ack;
        checkOutput(is_d ? "d_ack_width" : "i_ack_width", {31'd0, ack}, 32'd0);
    endtask

    task automatic applyStimulus(input bit is_d, input bit we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int lat);
        mem_lat = lat;
        sb.push_back(mkExp(is_d, we, be, addr, wdata));
        doReq(is_d, we, be, addr, wdata);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput(name, sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_be", {28'd0, mem_be}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_i_ack", {31'd0, i_ack}, 32'd0);
        checkOutput("rst_d_ack", {31'd0, d_ack}, 32'd0);
        checkOutput("rst_i_rdata", i_rdata, 32'd0);
        checkOutput("rst_d_rdata", d_rdata, 32'd0);
        checkOutput("rst_wr_active", {31'd0, wr_active}, 32'd0);
        checkOutput("rst_wr_addr", wr_addr, 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        $display("[TB] single fetch");
        mem_lat = 1;
        sb.push_back(mkExp(1'b0, 1'b0, 4'hF, 32'h10, 32'h0));
        i_addr = 32'h10; i_req = 1'b1;
        @(negedge clk); #1;
        checkOutput("grant_latency", {31'd0, mem_req}, 32'd1);
        doReq(1'b0, 1'b0, 4'hF, 32'h10, 32'h0);

        $display("[TB] store and load on data port");
        applyStimulus(1'b1, 1'b1, 4'hF, 32'd84, 32'd71, 3);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 2);
        applyStimulus(1'b1, 1'b1, 4'h3, 32'h44, 32'h1234_5678, 1);

        $display("[TB] simultaneous requests");
        mem_lat = 2;
        sb.push_back(mkExp(1'b1, 1'b0, 4'hF, 32'h200, 32'h0));
        sb.push_back(mkExp(1'b0, 1'b0, 4'hF, 32'h100, 32'h0));
        fork
            doReq(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
            doReq(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
        join
        waitDrain("simul_drain", 10);

        $display("[TB] continuous requests");
        mem_lat = 1;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            if (k % 5 == 4) sb.push_back(mkExp(1'b0, 1'b0, 4'hF, 32'h100, 32'h0));
            else            sb.push_back(mkExp(1'b1, 1'b0, 4'hF, 32'h200, 32'h0));
`else
            sb.push_back(mkExp(1'b1, 1'b0, 4'hF, 32'h200, 32'h0));
`endif
        end
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_wdata = '0;
        i_addr = 32'h100;
        d_req = 1'b1; i_req = 1'b1;
        waitDrain("starve_drain", 200);
        d_req = 1'b0; i_req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("starve_idle_mem_req", {31'd0, mem_req}, 32'd0);

        $display("[TB] mem_ready while idle");
        idle_pulse = 1'b1;
        @(negedge clk); #1;
        idle_pulse = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("idle_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("idle_i_rdata", i_rdata, exp_i_hold);
        checkOutput("idle_d_rdata", d_rdata, exp_d_hold);
        applyStimulus(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 1);

        $display("[TB] reset during store");
        mem_lat = 20;
        sb.push_back(mkExp(1'b1, 1'b1, 4'hF, 32'h80, 32'h55));
        d_we = 1'b1; d_be = 4'hF; d_addr = 32'h80; d_wdata = 32'h55; d_req = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rstmid_d_ack", {31'd0, d_ack}, 32'd0);
        checkOutput("rstmid_wr_active", {31'd0, wr_active}, 32'd0);
        sb.delete();
        exp_i_hold = '0;
        exp_d_hold = '0;
        d_req = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("post_rst_d_ack", {31'd0, d_ack}, 32'd0);
        checkOutput("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h84, 32'hCAFE, 1);
        waitDrain("final_drain", 10);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
